// File: rtl/flap_input_if.sv
// flap_input_if: button-conditioning bus between the player input block and
// the environment / physics stage.
//   btn_raw     : raw, asynchronous, bouncing button (1 = pressed)
//   frame_tick  : one-cycle strobe on the cycle physics samples flap_btn
//   flap_btn    : registered pending-flap level
//   btn_level   : debounced stable button level
//   press_count : count of debounced rising edges (wraps)
// master = environment side (drives button and tick), slave = flap_input.
interface flap_input_if;
  logic       btn_raw;
  logic       frame_tick;
  logic       flap_btn;
  logic       btn_level;
  logic [7:0] press_count;

  modport master (
    output btn_raw, frame_tick,
    input  flap_btn, btn_level, press_count
  );

  modport slave (
    input  btn_raw, frame_tick,
    output flap_btn, btn_level, press_count
  );
endinterface

// File: rtl/flap_input.sv
// flap_input: turns the raw player push-button into the flap_btn level that
// the bird physics stage samples once per frame. The button is synchronised,
// debounced, edge-detected, and each press is held pending until the next
// frame_tick consumes it, so short presses are never lost.
//
// Ports:
//   clk   : system clock (single domain)
//   reset : synchronous, active-high reset
//   bus   : flap_input_if.slave (btn_raw, frame_tick in; flap_btn,
//           btn_level, press_count out)
//
// Optional feature macro: FLAP_AUTO_REPEAT_EN
//   Defined   : a held button re-arms a flap every REPEAT_FRAMES frame ticks.
//   Undefined : one flap per debounced press; no repeat counter is built.
module flap_input #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_FRAMES   = 8
) (
  input  logic         clk,
  input  logic         reset,
  flap_input_if.slave  bus
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("flap_input: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
    $error("flap_input: DEBOUNCE_CYCLES must be at least 2");
  end
  if ((DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_chk_cnt
    $error("flap_input: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (REPEAT_FRAMES < 1 || REPEAT_FRAMES > 16) begin : g_chk_rep
    $error("flap_input: REPEAT_FRAMES must be in 1..16");
  end

  typedef enum logic {IDLE, ARMED} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   stable_q, stable_d;
  logic                   stable_dly_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press;
  logic                   trigger;
  state_e                 state_q;
  logic                   flap_q;
  logic [7:0]             count_q;

  // Sync chain and stable level reset to 1 so a button held through reset
  // is not seen as a press; a release followed by a new press is needed.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_raw};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press = stable_q & ~stable_dly_q;

`ifdef FLAP_AUTO_REPEAT_EN
  logic [3:0] rep_q;
  logic       auto_arm;

  // Auto-repeat always coincides with a frame_tick, so it follows the
  // press+tick rules: re-arms from IDLE, consumes-and-coalesces in ARMED.
  assign auto_arm = stable_q & bus.frame_tick & (rep_q == 4'(REPEAT_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (reset)                              rep_q <= '0;
    else if (press || !stable_q || auto_arm) rep_q <= '0;
    else if (bus.frame_tick)                 rep_q <= rep_q + 4'd1;
  end

  assign trigger = press | auto_arm;
`else
  assign trigger = press;
`endif

  // flap_q is loaded alongside the state so it is a registered decode of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      flap_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q <= ARMED;
            flap_q  <= 1'b1;
          end
        end
        ARMED: begin
          if (bus.frame_tick) begin
            state_q <= IDLE;
            flap_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          flap_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      count_q <= '0;
    else if (press) count_q <= count_q + 8'd1;
  end

  assign bus.flap_btn    = flap_q;
  assign bus.btn_level   = stable_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_flap_input.sv
module tb_flap_input;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_fail;

  flap_input_if bus ();

  flap_input #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4),
    .REPEAT_FRAMES   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable and inputs may be changed.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc();
  endtask

  // Reset with button released, then let stable settle to 0.
  task automatic do_reset();
    bus.btn_raw    = 1'b0;
    bus.frame_tick = 1'b0;
    reset          = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(10);
  endtask

  task automatic clean_press();
    bus.btn_raw = 1'b1;
    wait_cycles(10);
    bus.btn_raw = 1'b0;
    wait_cycles(10);
  endtask

  task automatic test_reset();
    bus.btn_raw    = 1'b1;
    bus.frame_tick = 1'b0;
    reset          = 1'b1;
    wait_cycles(2);
    n_checks++;
    if (bus.flap_btn !== 1'b0 || bus.btn_level !== 1'b1 || bus.press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values: flap=%b level=%b count=%0d, want 0 1 0",
               bus.flap_btn, bus.btn_level, bus.press_count);
    end
    reset = 1'b0;
    for (int unsigned k = 0; k < 20; k++) begin
      cyc();
      n_checks++;
      if (bus.flap_btn !== 1'b0 || bus.press_count !== 8'd0) begin
        n_fail++;
        $display("FAIL held_through_reset k=%0d: flap=%b count=%0d, want 0 0",
                 k, bus.flap_btn, bus.press_count);
      end
    end
    // Release, press again to arm, then reset while ARMED.
    bus.btn_raw = 1'b0;
    wait_cycles(10);
    bus.btn_raw = 1'b1;
    wait_cycles(10);
    n_checks++;
    if (bus.flap_btn !== 1'b1 || bus.press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL armed_before_reset: flap=%b count=%0d, want 1 1",
               bus.flap_btn, bus.press_count);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_checks++;
    if (bus.flap_btn !== 1'b0 || bus.press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_while_armed: flap=%b count=%0d, want 0 0",
               bus.flap_btn, bus.press_count);
    end
    wait_cycles(10);
    n_checks++;
    if (bus.flap_btn !== 1'b0 || bus.press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL held_after_midreset: flap=%b count=%0d, want 0 0",
               bus.flap_btn, bus.press_count);
    end
  endtask

  task automatic test_tap();
    do_reset();
    n_checks++;
    if (bus.btn_level !== 1'b0 || bus.flap_btn !== 1'b0 || bus.press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL tap_idle: level=%b flap=%b count=%0d, want 0 0 0",
               bus.btn_level, bus.flap_btn, bus.press_count);
    end
    bus.btn_raw = 1'b1;
    for (int unsigned k = 0; k < 9; k++) begin
      cyc();  // edge k
      n_checks++;
      if (bus.btn_level !== (k >= 5) || bus.flap_btn !== (k >= 6)) begin
        n_fail++;
        $display("FAIL tap_latency edge=%0d: level=%b flap=%b, want %b %b",
                 k, bus.btn_level, bus.flap_btn, (k >= 5), (k >= 6));
      end
    end
    n_checks++;
    if (bus.press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL tap_count: got %0d want 1", bus.press_count);
    end
    wait_cycles(10);
    bus.frame_tick = 1'b1;
    n_checks++;
    if (bus.flap_btn !== 1'b1) begin
      n_fail++;
      $display("FAIL tap_tick_cycle: flap=%b want 1", bus.flap_btn);
    end
    cyc();
    bus.frame_tick = 1'b0;
    n_checks++;
    if (bus.flap_btn !== 1'b0) begin
      n_fail++;
      $display("FAIL tap_after_tick: flap=%b want 0", bus.flap_btn);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    bus.btn_raw = 1'b1; wait_cycles(3);
    bus.btn_raw = 1'b0; wait_cycles(2);
    bus.btn_raw = 1'b1; wait_cycles(3);
    bus.btn_raw = 1'b0;
    for (int unsigned k = 0; k < 12; k++) begin
      cyc();
      n_checks++;
      if (bus.btn_level !== 1'b0 || bus.flap_btn !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce k=%0d: level=%b flap=%b, want 0 0",
                 k, bus.btn_level, bus.flap_btn);
      end
    end
    n_checks++;
    if (bus.press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL bounce_count: got %0d want 0", bus.press_count);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    clean_press();
    clean_press();
    n_checks++;
    if (bus.flap_btn !== 1'b1 || bus.press_count !== 8'd2) begin
      n_fail++;
      $display("FAIL coalesce_armed: flap=%b count=%0d, want 1 2",
               bus.flap_btn, bus.press_count);
    end
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    n_checks++;
    if (bus.flap_btn !== 1'b0) begin
      n_fail++;
      $display("FAIL coalesce_first_tick: flap=%b want 0", bus.flap_btn);
    end
    wait_cycles(5);
    bus.frame_tick = 1'b1;
    n_checks++;
    if (bus.flap_btn !== 1'b0) begin
      n_fail++;
      $display("FAIL coalesce_second_tick: flap=%b want 0", bus.flap_btn);
    end
    cyc();
    bus.frame_tick = 1'b0;
    n_checks++;
    if (bus.flap_btn !== 1'b0 || bus.press_count !== 8'd2) begin
      n_fail++;
      $display("FAIL coalesce_after: flap=%b count=%0d, want 0 2",
               bus.flap_btn, bus.press_count);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.btn_raw = 1'b1;
    wait_cycles(6);  // after edge 5: press pulse is live for edge 6
    bus.frame_tick = 1'b1;
    n_checks++;
    if (bus.flap_btn !== 1'b0 || bus.btn_level !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_tick_cycle: flap=%b level=%b, want 0 1",
               bus.flap_btn, bus.btn_level);
    end
    cyc();
    bus.frame_tick = 1'b0;
    n_checks++;
    if (bus.flap_btn !== 1'b1 || bus.press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL simul_armed: flap=%b count=%0d, want 1 1",
               bus.flap_btn, bus.press_count);
    end
    wait_cycles(5);
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    n_checks++;
    if (bus.flap_btn !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_consumed: flap=%b want 0", bus.flap_btn);
    end
  endtask

  // Held button, frame_tick every 10 cycles, 7 ticks.
  task automatic test_held();
    logic exp_during, exp_after;
    do_reset();
    bus.btn_raw = 1'b1;
    wait_cycles(10);
    for (int unsigned t = 1; t <= 7; t++) begin
`ifdef FLAP_AUTO_REPEAT_EN
      exp_during = (t % 3 == 1);
      exp_after  = (t % 3 == 0);
`else
      exp_during = (t == 1);
      exp_after  = 1'b0;
`endif
      bus.frame_tick = 1'b1;
      n_checks++;
      if (bus.flap_btn !== exp_during) begin
        n_fail++;
        $display("FAIL held_tick%0d_during: flap=%b want %b", t, bus.flap_btn, exp_during);
      end
      cyc();
      bus.frame_tick = 1'b0;
      n_checks++;
      if (bus.flap_btn !== exp_after) begin
        n_fail++;
        $display("FAIL held_tick%0d_after: flap=%b want %b", t, bus.flap_btn, exp_after);
      end
      wait_cycles(9);
    end
    n_checks++;
    if (bus.press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL held_count: got %0d want 1", bus.press_count);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.btn_raw    = 1'b1;
    bus.frame_tick = 1'b0;
    test_reset();
    test_tap();
    test_bounce();
    test_coalesce();
    test_simultaneous();
    test_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flap_input.md
Name: flap_input

Overview:
- Conditions the raw player push-button into the `flap_btn` level that the bird physics stage consumes.
- Synchronises the button, debounces it, detects presses, and holds each press pending until the physics frame update samples it.
- Without the hold, a short press would be missed, because physics samples `flap_btn` only once per frame.
- Sits directly upstream of the bird physics stage.

Parameters:
- SYNC_STAGES, 2: synchroniser flop count; minimum 2.
- DEBOUNCE_CYCLES, 500000: number of consecutive cycles the synchronised input must differ from the stable level before the stable level flips; minimum 2.
- CNT_W, 20: debounce counter width; requires 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_FRAMES, 8: frame count between auto-repeat flaps; used only with the optional feature.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  1  asynchronous, bouncing button; 1 = pressed.
- frame_tick  input  1  one-cycle strobe, high on the cycle the physics stage samples `flap_btn`.
- flap_btn  output  1  registered pending-flap level, fed to the physics stage.
- btn_level  output  1  debounced stable button level.
- press_count  output  8  count of debounced rising edges; wraps 255 -> 0.

Behaviour:
- Reset values: sync flops = 1, stable = 1, debounce counter = 0, FSM = IDLE, flap_btn = 0, press_count = 0, repeat counter = 0. btn_level = stable, so it reads 1 out of reset.
- Stable and sync reset to 1 deliberately: a button held through reset produces no press. A release, then a new press, is required.
- Synchroniser: SYNC_STAGES-flop shift chain on btn_raw. Its last stage is `sync`.
- Debounce:
  - sync == stable: counter <= 0.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Otherwise: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles resets the counter and produces no change.
- Press detection: press = stable rising edge, one cycle wide, combinational from stable and its registered copy. press_count increments on every press, including coalesced ones.
- FSM states: IDLE (flap_btn = 0) and ARMED (flap_btn = 1). flap_btn is a registered decode of the state.
  - IDLE -> ARMED on press.
  - ARMED -> IDLE on frame_tick. flap_btn is high during the frame_tick cycle, so physics samples 1, and it drops after that edge.
  - Press while ARMED: coalesced. Stays ARMED; press_count still increments.
  - Press and frame_tick in the same cycle while IDLE: go ARMED. That tick samples 0; the next tick consumes the press.
  - Press and frame_tick in the same cycle while ARMED: go IDLE; the new press is coalesced into the consumed one.
  - frame_tick while IDLE: no effect.
- Latency: with btn_raw first sampled high at edge 0 and held clean, stable rises after edge DEBOUNCE_CYCLES+SYNC_STAGES-1 and flap_btn rises after edge DEBOUNCE_CYCLES+SYNC_STAGES.
- Release has the same debounce latency and no FSM effect.
- Reset mid-operation: reset wins over all other events. A pending flap is discarded and flap_btn is 0 on the cycle after reset.

Optional Feature:
- Macro: FLAP_AUTO_REPEAT_EN.
- Defined:
  - A 4-bit repeat counter clears on press and whenever stable == 0.
  - While stable == 1, it increments on each frame_tick.
  - When it reaches REPEAT_FRAMES-1 on a frame_tick, it clears and the FSM is forced to ARMED, using the same rules as a press. press_count does not increment on auto-repeat.
- Undefined:
  - No repeat counter is built.
  - A held button yields exactly one flap per debounced press.

Test Plan:
- Tap: DEBOUNCE_CYCLES=4, reset then release, btn_raw 0->1 held -> btn_level 1 after edge 5, flap_btn 1 after edge 6, press_count=1; frame_tick 10 cycles later -> flap_btn 1 that cycle, 0 next.
- Bounce: btn_raw high 3 cycles, low 2, high 3, then low -> btn_level never 1, flap_btn stays 0, press_count=0.
- Coalesce: two clean presses before any frame_tick -> single ARMED, press_count=2, first frame_tick clears, second frame_tick sees flap_btn=0.
- Simultaneous: press edge coincides with frame_tick in IDLE -> flap_btn 0 at that tick, 1 after, cleared by next frame_tick.
- Reset: hold btn_raw=1 across reset and 20 cycles after -> flap_btn 0, press_count 0; reset asserted while ARMED -> flap_btn 0 next cycle.
- With FLAP_AUTO_REPEAT_EN, REPEAT_FRAMES=3, button held, frame_tick every 10 cycles -> flap re-armed on every 3rd frame_tick after the initial press, press_count stays 1.
